// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one recoded digit per cycle, LSB first.
// Signed or unsigned operands, chosen per operation by signed_mode.
module booth_r4_seq_mult #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [X_WIDTH-1:0]         x_in,
  input  logic [Y_WIDTH-1:0]         y_in,
  output logic                       busy,
  output logic                       done,
  output logic [X_WIDTH+Y_WIDTH-1:0] product
);

  localparam int unsigned PW = X_WIDTH + Y_WIDTH;
  localparam int unsigned AW = PW + 3;
  localparam int unsigned YW = Y_WIDTH + 3;
  localparam int unsigned CW = $clog2(Y_WIDTH / 2 + 2);
  localparam logic [CW-1:0] N_SIGNED   = CW'(Y_WIDTH / 2);
  localparam logic [CW-1:0] N_UNSIGNED = CW'(Y_WIDTH / 2 + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_acc;
  logic [AW-1:0]   r_mcand;
  logic [YW-1:0]   r_y;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_nd;

  logic            w_accept;
  logic            w_last;
  logic            w_nz;
  logic            w_two;
  logic            w_neg;
  logic [AW-1:0]   w_sel;
  logic [AW-1:0]   w_addend;
  logic [AW-1:0]   w_acc_next;
  logic [AW-1:0]   w_xext;
  logic [YW-1:0]   w_yext;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_cnt == r_nd - CW'(1));

  // Extending straight to accumulator width equals the (X_WIDTH+1)-bit extension
  // followed by sign extension, since the value already fits in X_WIDTH+1 bits.
  assign w_xext = {{(AW - X_WIDTH){signed_mode & x_in[X_WIDTH-1]}}, x_in};
  // Bit 0 is the implicit y[-1] = 0 of the first triplet.
  assign w_yext = {{2{signed_mode & y_in[Y_WIDTH-1]}}, y_in, 1'b0};

  always_comb begin
    w_nz  = 1'b0;
    w_two = 1'b0;
    w_neg = 1'b0;
    case (r_y[2:0])
      3'b001, 3'b010: w_nz = 1'b1;
      3'b011:         begin w_nz = 1'b1; w_two = 1'b1; end
      3'b100:         begin w_nz = 1'b1; w_two = 1'b1; w_neg = 1'b1; end
      3'b101, 3'b110: begin w_nz = 1'b1; w_neg = 1'b1; end
      default:        w_nz = 1'b0;
    endcase
    w_sel      = w_two ? {r_mcand[AW-2:0], 1'b0} : r_mcand;
    w_addend   = w_nz ? (w_neg ? ~w_sel : w_sel) : '0;
    w_acc_next = r_acc + w_addend + AW'(w_neg);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (w_last)   w_state_next = S_DONE;
      S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_nd    <= '0;
      product <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_mcand <= w_xext;
      r_y     <= w_yext;
      r_cnt   <= '0;
      r_nd    <= signed_mode ? N_SIGNED : N_UNSIGNED;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_next;
      r_mcand <= {r_mcand[AW-3:0], 2'b00};
      r_y     <= {2'b00, r_y[YW-1:2]};
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) product <= w_acc_next[PW-1:0];
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed-vector bench for booth_r4_seq_mult at the default 8x8 size.
module tb_booth_r4_seq_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int unsigned n_vec;
  int unsigned n_err;

  booth_r4_seq_mult #(.X_WIDTH(8), .Y_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .x_in        (x_in),
    .y_in        (y_in),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // One full operation: accept, N busy cycles, one done cycle, then idle.
  task automatic run_op(input string tag, input logic sm, input logic [7:0] x,
                        input logic [7:0] y, input int unsigned n, input logic [15:0] exp);
    signed_mode = sm;
    x_in        = x;
    y_in        = y;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    x_in        = ~x;
    y_in        = y ^ 8'h5A;
    signed_mode = ~sm;
    for (int unsigned i = 0; i < n; i++) begin
      check({tag, "/run"}, {30'd0, busy, done}, 32'b10);
      tick();
    end
    check({tag, "/done"}, {30'd0, busy, done}, 32'b01);
    check({tag, "/prod"}, {16'd0, product}, {16'd0, exp});
    tick();
    check({tag, "/idle"}, {30'd0, busy, done}, 32'b00);
    check({tag, "/hold"}, {16'd0, product}, {16'd0, exp});
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    x_in        = 8'h00;
    y_in        = 8'h00;
    tick();
    tick();
    check("reset/flags", {30'd0, busy, done}, 32'b00);
    check("reset/prod",  {16'd0, product}, 32'h0);

    // First edge with rst low also accepts start.
    rst = 1'b0;
    run_op("s_m128_m128", 1'b1, 8'h80, 8'h80, 4, 16'h4000);
    run_op("u_ff_ff",     1'b0, 8'hFF, 8'hFF, 5, 16'hFE01);
    run_op("s_m1_1",      1'b1, 8'hFF, 8'h01, 4, 16'hFFFF);
    run_op("u_ff_1",      1'b0, 8'hFF, 8'h01, 5, 16'h00FF);
    run_op("s_127_m128",  1'b1, 8'h7F, 8'h80, 4, 16'hC080);
    run_op("u_200_3",     1'b0, 8'hC8, 8'h03, 5, 16'h0258);
    run_op("s_m7_6",      1'b1, 8'hF9, 8'h06, 4, 16'hFFD6);
    run_op("u_80_80",     1'b0, 8'h80, 8'h80, 5, 16'h4000);
    run_op("u_zero",      1'b0, 8'h00, 8'hAB, 5, 16'h0000);
    run_op("s_zero",      1'b1, 8'h9C, 8'h00, 4, 16'h0000);

    // Start during RUN is ignored: signed 5*7 completes unchanged.
    signed_mode = 1'b1; x_in = 8'h05; y_in = 8'h07; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    x_in = 8'h03; y_in = 8'h03; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign/run", {30'd0, busy, done}, 32'b10);
    tick();
    check("ign/run4", {30'd0, busy, done}, 32'b10);
    tick();
    check("ign/done", {30'd0, busy, done}, 32'b01);
    check("ign/prod", {16'd0, product}, 32'h0023);

    // Back-to-back: start held in DONE with signed 3*-5.
    signed_mode = 1'b1; x_in = 8'h03; y_in = 8'hFB; start = 1'b1;
    tick();
    start = 1'b0; x_in = 8'h7E; y_in = 8'h11;
    check("b2b/busy", {30'd0, busy, done}, 32'b10);
    check("b2b/held", {16'd0, product}, 32'h0023);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("b2b/run",  {30'd0, busy, done}, 32'b10);
      check("b2b/held", {16'd0, product}, 32'h0023);
    end
    tick();
    check("b2b/done", {30'd0, busy, done}, 32'b01);
    check("b2b/prod", {16'd0, product}, 32'hFFF1);
    tick();
    check("b2b/idle", {30'd0, busy, done}, 32'b00);

    // Reset two cycles into an operation aborts it with no done pulse.
    signed_mode = 1'b0; x_in = 8'h11; y_in = 8'h22; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst/flags", {30'd0, busy, done}, 32'b00);
    check("rst/prod",  {16'd0, product}, 32'h0);
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      check("rst/nodone", {30'd0, busy, done}, 32'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
